// File: rtl/mips_cpu_harvard_core.sv
// mips_cpu_harvard_core
//   Single-cycle MIPS-I integer core with separate instruction and data buses.
//   Every enabled clock commits one instruction; branches and jumps have one
//   architectural delay slot. The core halts once the PC reaches address 0.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   active         out  1 while running, 0 once PC == 0
//   register_v0    out  live value of GPR $2
//   clk_enable     in   1: commit on clk, 0: freeze all state
//   instr_address  out  byte address of the current instruction (PC)
//   instr_readdata in   instruction word, little-endian bus order
//   data_address   out  load/store byte address (rs + sext(imm16))
//   data_write     out  store strobe
//   data_read      out  load strobe
//   data_writedata out  store data, little-endian bus order
//   data_readdata  in   load data, little-endian, valid combinationally
module mips_cpu_harvard_core #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Buses are little-endian; the core works on big-endian-numbered words.
  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Declaration initialisers give the reset state at power-up as well.
  logic [31:0] r_pc  = RESET_VECTOR;
  logic [31:0] r_npc = RESET_VECTOR + 32'd4;
  logic [31:0] r_gpr [32] = '{default: 32'd0};

  logic [31:0] w_instr;
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic        w_commit;

  logic        w_wb_en;
  logic [4:0]  w_wb_reg;
  logic [31:0] w_wb_data;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_is_lw;
  logic        w_is_sw;

  assign w_instr  = bswap(instr_readdata);
  assign w_op     = w_instr[31:26];
  assign w_rs     = w_instr[25:21];
  assign w_rt     = w_instr[20:16];
  assign w_rd     = w_instr[15:11];
  assign w_shamt  = w_instr[10:6];
  assign w_funct  = w_instr[5:0];
  assign w_imm    = w_instr[15:0];
  assign w_sext   = {{16{w_imm[15]}}, w_imm};
  assign w_zext   = {16'd0, w_imm};
  assign w_rs_val = r_gpr[w_rs];
  assign w_rt_val = r_gpr[w_rt];

  // r_npc is the delay-slot address, which is the base for both target kinds.
  assign w_br_target = r_npc + (w_sext << 2);
  assign w_j_target  = {r_npc[31:28], w_instr[25:0], 2'b00};

  assign active   = (r_pc != 32'd0);
  assign w_commit = clk_enable & active;

  always_comb begin
    w_wb_en   = 1'b0;
    w_wb_reg  = w_rt;
    w_wb_data = 32'd0;
    w_taken   = 1'b0;
    w_target  = w_br_target;
    w_is_lw   = 1'b0;
    w_is_sw   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_wb_reg = w_rd;
        w_wb_en  = 1'b1;
        case (w_funct)
          FN_SLL:  w_wb_data = w_rt_val << w_shamt;
          FN_SRL:  w_wb_data = w_rt_val >> w_shamt;
          FN_SRA:  w_wb_data = $signed(w_rt_val) >>> w_shamt;
          FN_JR: begin
            w_wb_en  = 1'b0;
            w_taken  = 1'b1;
            w_target = w_rs_val;
          end
          FN_ADDU: w_wb_data = w_rs_val + w_rt_val;
          FN_SUBU: w_wb_data = w_rs_val - w_rt_val;
          FN_AND:  w_wb_data = w_rs_val & w_rt_val;
          FN_OR:   w_wb_data = w_rs_val | w_rt_val;
          FN_XOR:  w_wb_data = w_rs_val ^ w_rt_val;
          FN_NOR:  w_wb_data = ~(w_rs_val | w_rt_val);
          FN_SLT:  w_wb_data = {31'd0, $signed(w_rs_val) < $signed(w_rt_val)};
          FN_SLTU: w_wb_data = {31'd0, w_rs_val < w_rt_val};
          default: w_wb_en = 1'b0;
        endcase
      end
      OP_J: begin
        w_taken  = 1'b1;
        w_target = w_j_target;
      end
      OP_BEQ: w_taken = (w_rs_val == w_rt_val);
      OP_BNE: w_taken = (w_rs_val != w_rt_val);
      OP_ADDIU: begin
        w_wb_en   = 1'b1;
        w_wb_data = w_rs_val + w_sext;
      end
      OP_SLTI: begin
        w_wb_en   = 1'b1;
        w_wb_data = {31'd0, $signed(w_rs_val) < $signed(w_sext)};
      end
      OP_SLTIU: begin
        w_wb_en   = 1'b1;
        w_wb_data = {31'd0, w_rs_val < w_sext};
      end
      OP_ANDI: begin
        w_wb_en   = 1'b1;
        w_wb_data = w_rs_val & w_zext;
      end
      OP_ORI: begin
        w_wb_en   = 1'b1;
        w_wb_data = w_rs_val | w_zext;
      end
      OP_XORI: begin
        w_wb_en   = 1'b1;
        w_wb_data = w_rs_val ^ w_zext;
      end
      OP_LUI: begin
        w_wb_en   = 1'b1;
        w_wb_data = {w_imm, 16'd0};
      end
      OP_LW: begin
        w_is_lw   = 1'b1;
        w_wb_en   = 1'b1;
        w_wb_data = bswap(data_readdata);
      end
      OP_SW: w_is_sw = 1'b1;
      default: ;
    endcase
  end

  assign instr_address  = r_pc;
  assign register_v0    = r_gpr[2];
  assign data_address   = w_rs_val + w_sext;
  assign data_read      = w_is_lw & w_commit;
  assign data_write     = w_is_sw & w_commit;
  assign data_writedata = bswap(w_rt_val);

  // Reset also drops any pending branch because r_npc is reloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc  <= RESET_VECTOR;
      r_npc <= RESET_VECTOR + 32'd4;
    end else if (w_commit) begin
      r_pc  <= r_npc;
      r_npc <= w_taken ? w_target : r_npc + 32'd4;
    end
  end

  // $0 is never written, so it always reads back as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_gpr[i] <= 32'd0;
    end else if (w_commit && w_wb_en && (w_wb_reg != 5'd0)) begin
      r_gpr[w_wb_reg] <= w_wb_data;
    end
  end

endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
module tb_mips_cpu_harvard_core;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active;
  logic [31:0] register_v0;
  logic        clk_enable = 1'b1;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  logic [31:0] rom  [0:127];
  logic [31:0] dmem [0:255];
  logic [31:0] rom_off;
  int          rom_n;
  st_t         exp_q[$];
  st_t         obs_q[$];
  int          rd_cycles;
  int          total = 0;
  int          passed = 0;

  mips_cpu_harvard_core dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .clk_enable(clk_enable), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .data_address(data_address),
    .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  always #5 clk = ~clk;

  // Instruction ROM at BFC00000, NOP everywhere else.
  assign rom_off        = instr_address - 32'hBFC00000;
  assign instr_readdata = (rom_off < 32'd512) ? rom[rom_off[8:2]] : 32'h0;

  // Data memory keeps bus byte order untouched.
  assign data_readdata = dmem[data_address[9:2]];
  always @(posedge clk) if (data_write) dmem[data_address[9:2]] <= data_writedata;

  // Record every store and count load-strobe cycles mid-cycle.
  always @(negedge clk) begin
    if (data_write === 1'b1) obs_q.push_back('{addr: data_address, data: data_writedata});
    if (data_read === 1'b1) rd_cycles++;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 32'h0;
    rom_n = 0;
  endtask

  task automatic emit(input logic [31:0] ins);
    rom[rom_n] = bsw(ins);
    rom_n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    rd_cycles = 0;
  endtask

  task automatic run_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_to_halt(input int max_cycles, output bit halted);
    int n = 0;
    while (active === 1'b1 && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    halted = (active === 1'b0);
  endtask

  task automatic prog_arith(input bit v0_one);
    clear_rom();
    emit(enc_i('h09, 4, 4, 16'hFFFF));           // ADDIU $4,$4,-1
    emit(enc_r(0, 4, 4, 16, 'h00));               // SLL $4,$4,16
    emit(enc_i('h09, 4, 4, 16'hFFB3));           // ADDIU $4,$4,0xFFB3
    emit(enc_i('h09, 5, 5, 16'd11));             // ADDIU $5,$5,11
    if (v0_one) emit(enc_r(4, 5, 2, 0, 'h2A));    // SLT $2,$4,$5
    else        emit(enc_r(5, 4, 2, 0, 'h2A));    // SLT $2,$5,$4
    emit(enc_i('h2B, 0, 4, 16'd0));              // SW $4,0($0)
    emit(enc_r(0, 0, 0, 0, 'h08));                // JR $0
    emit(32'h0);
  endtask

  task automatic prog_mem();
    clear_rom();
    emit(enc_i('h0F, 0, 3, 16'h1234));           // LUI $3,0x1234
    emit(enc_i('h0D, 3, 3, 16'h5678));           // ORI $3,$3,0x5678
    emit(enc_i('h09, 0, 6, 16'h1000));           // ADDIU $6,$0,0x1000
    emit(enc_i('h2B, 6, 3, 16'd0));              // SW $3,0($6)
    emit(enc_i('h23, 6, 2, 16'd0));              // LW $2,0($6)
    emit(enc_r(0, 0, 0, 0, 'h08));
    emit(32'h0);
  endtask

  task automatic prog_branch();
    clear_rom();
    emit(enc_i('h04, 0, 0, 16'd2));              // BEQ $0,$0,+2
    emit(enc_i('h09, 2, 2, 16'd1));              // delay slot
    emit(enc_i('h09, 2, 2, 16'd5));              // skipped
    emit(enc_r(0, 0, 0, 0, 'h08));
    emit(32'h0);
  endtask

  task automatic test_reset();
    prog_arith(1'b0);
    #1;
    total++;
    if (instr_address !== 32'hBFC00000 || active !== 1'b1 || register_v0 !== 32'h0) begin
      $display("FAIL reset_state: pc=%h active=%b v0=%h, required pc=bfc00000 active=1 v0=0",
               instr_address, active, register_v0);
    end else passed++;
    total++;
    if (data_write !== 1'b0) $display("FAIL reset_nowrite: data_write=%b required 0", data_write);
    else passed++;
  endtask

  task automatic test_arith(input bit v0_one);
    bit halted;
    st_t e, o;
    logic [31:0] v0_exp;
    v0_exp = v0_one ? 32'd1 : 32'd0;
    prog_arith(v0_one);
    do_reset();
    exp_q.push_back('{addr: 32'h0, data: 32'hB3FFFEFF});
    run_to_halt(200, halted);
    total++;
    if (!halted) $display("FAIL arith_halt: active=%b pc=%h, required halt", active, instr_address);
    else passed++;
    total++;
    if (register_v0 !== v0_exp) $display("FAIL arith_v0: v0=%h required %h", register_v0, v0_exp);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL arith_store: no store seen, required %h@%h", e.data, e.addr);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL arith_store: got %h@%h required %h@%h", o.data, o.addr, e.data, e.addr);
        else passed++;
      end
    end
    run_n(5);
    total++;
    if (instr_address !== 32'h0 || active !== 1'b0 || data_write !== 1'b0 ||
        register_v0 !== v0_exp || obs_q.size() != 0) begin
      $display("FAIL halt_hold: pc=%h active=%b wr=%b v0=%h extra_stores=%0d, required pc=0 active=0 wr=0 v0=%h none",
               instr_address, active, data_write, register_v0, obs_q.size(), v0_exp);
    end else passed++;
  endtask

  task automatic test_load_store();
    bit halted;
    st_t e, o;
    prog_mem();
    do_reset();
    exp_q.push_back('{addr: 32'h1000, data: 32'h78563412});
    run_to_halt(200, halted);
    total++;
    if (!halted || register_v0 !== 32'h12345678)
      $display("FAIL mem_v0: halted=%b v0=%h required halted=1 v0=12345678", halted, register_v0);
    else passed++;
    total++;
    if (rd_cycles != 1) $display("FAIL mem_read_strobe: cycles=%0d required 1", rd_cycles);
    else passed++;
    total++;
    if (obs_q.size() != 1) $display("FAIL mem_write_count: stores=%0d required 1", obs_q.size());
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL mem_store: no store seen, required %h@%h", e.data, e.addr);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL mem_store: got %h@%h required %h@%h", o.data, o.addr, e.data, e.addr);
        else passed++;
      end
    end
  endtask

  task automatic test_branch();
    bit halted;
    prog_branch();
    do_reset();
    run_to_halt(100, halted);
    total++;
    if (!halted || register_v0 !== 32'd1)
      $display("FAIL branch_delay: halted=%b v0=%h required halted=1 v0=1", halted, register_v0);
    else passed++;
  endtask

  task automatic test_alu();
    bit halted;
    st_t e, o;
    int m;
    logic [31:0] jaddr;
    clear_rom();
    emit(enc_i('h0F, 0, 8, 16'h8000));             // LUI $8,0x8000
    emit(enc_i('h0D, 8, 8, 16'h00F0));             // ORI
    emit(enc_r(0, 8, 9, 4, 'h03));  emit(enc_i('h2B, 0, 9, 16'd0));    // SRA
    emit(enc_r(0, 8, 10, 4, 'h02)); emit(enc_i('h2B, 0, 10, 16'd4));   // SRL
    emit(enc_i('h09, 0, 11, 16'hFFFD));            // $11 = -3
    emit(enc_r(0, 11, 12, 0, 'h23)); emit(enc_i('h2B, 0, 12, 16'd8));  // SUBU
    emit(enc_r(8, 0, 13, 0, 'h27)); emit(enc_i('h2B, 0, 13, 16'd12));  // NOR
    emit(enc_i('h0E, 8, 14, 16'hFFFF)); emit(enc_i('h2B, 0, 14, 16'd16)); // XORI
    emit(enc_i('h0C, 11, 15, 16'h8001)); emit(enc_i('h2B, 0, 15, 16'd20)); // ANDI
    emit(enc_r(8, 11, 20, 0, 'h24)); emit(enc_i('h2B, 0, 20, 16'd24)); // AND
    emit(enc_r(8, 11, 21, 0, 'h26)); emit(enc_i('h2B, 0, 21, 16'd28)); // XOR
    emit(enc_r(12, 11, 16, 0, 'h2B));              // SLTU 3<-3u  -> 1
    emit(enc_i('h0B, 11, 17, 16'hFFFF));           // SLTIU       -> 1
    emit(enc_i('h0A, 11, 19, 16'hFFFE));           // SLTI -3<-2  -> 1
    emit(enc_r(11, 12, 22, 0, 'h2A));              // SLT -3<3    -> 1
    emit(enc_r(11, 12, 23, 0, 'h2B));              // SLTU        -> 0
    emit(enc_r(12, 11, 24, 0, 'h2A));              // SLT 3<-3    -> 0
    emit(enc_r(0, 17, 17, 1, 'h00));
    emit(enc_r(0, 19, 19, 2, 'h00));
    emit(enc_r(0, 22, 22, 3, 'h00));
    emit(enc_r(16, 17, 18, 0, 'h25));
    emit(enc_r(18, 19, 18, 0, 'h25));
    emit(enc_r(18, 22, 18, 0, 'h25));
    emit(enc_r(18, 23, 18, 0, 'h25));
    emit(enc_r(18, 24, 18, 0, 'h21));              // ADDU
    emit(enc_i('h2B, 0, 18, 16'd32));
    emit(enc_i('h09, 0, 0, 16'd5));                // write to $0 discarded
    emit(enc_i('h2B, 0, 0, 16'd40));
    emit(enc_i('h05, 12, 12, 16'd2));              // BNE not taken
    emit(enc_i('h09, 0, 26, 16'd1));
    emit(enc_i('h09, 26, 26, 16'd2));
    emit(enc_i('h05, 12, 11, 16'd2));              // BNE taken
    emit(enc_i('h09, 26, 26, 16'd4));
    emit(enc_i('h09, 26, 26, 16'd8));
    emit(enc_i('h2B, 0, 26, 16'd44));
    m = rom_n;
    jaddr = 32'hBFC00000 + 32'(4 * (m + 3));
    emit({6'h02, jaddr[27:2]});                    // J over one instruction
    emit(enc_i('h09, 0, 27, 16'd1));
    emit(enc_i('h09, 27, 27, 16'd16));
    emit(enc_i('h2B, 0, 27, 16'd48));
    emit(enc_i('h23, 0, 2, 16'd44));               // LW $2,44($0)
    emit(enc_r(0, 0, 0, 0, 'h08));
    emit(32'h0);
    do_reset();
    exp_q.push_back('{addr: 32'd0,  data: bsw(32'hF800000F)});
    exp_q.push_back('{addr: 32'd4,  data: bsw(32'h0800000F)});
    exp_q.push_back('{addr: 32'd8,  data: bsw(32'h00000003)});
    exp_q.push_back('{addr: 32'd12, data: bsw(32'h7FFFFF0F)});
    exp_q.push_back('{addr: 32'd16, data: bsw(32'h8000FF0F)});
    exp_q.push_back('{addr: 32'd20, data: bsw(32'h00008001)});
    exp_q.push_back('{addr: 32'd24, data: bsw(32'h800000F0)});
    exp_q.push_back('{addr: 32'd28, data: bsw(32'h7FFFFF0D)});
    exp_q.push_back('{addr: 32'd32, data: bsw(32'h0000000F)});
    exp_q.push_back('{addr: 32'd40, data: 32'h0});
    exp_q.push_back('{addr: 32'd44, data: bsw(32'h00000007)});
    exp_q.push_back('{addr: 32'd48, data: bsw(32'h00000001)});
    run_to_halt(400, halted);
    total++;
    if (!halted || register_v0 !== 32'd7)
      $display("FAIL alu_v0: halted=%b v0=%h required halted=1 v0=7", halted, register_v0);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL alu_store: no store seen, required %h@%h", e.data, e.addr);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL alu_store: got %h@%h required %h@%h", o.data, o.addr, e.data, e.addr);
        else passed++;
      end
    end
  endtask

  task automatic test_clk_enable();
    bit halted;
    st_t e, o;
    prog_mem();
    do_reset();
    exp_q.push_back('{addr: 32'h1000, data: 32'h78563412});
    run_n(3);
    total++;
    if (instr_address !== 32'hBFC0000C) $display("FAIL pause_entry: pc=%h required bfc0000c", instr_address);
    else passed++;
    clk_enable = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (instr_address !== 32'hBFC0000C || data_write !== 1'b0 || data_read !== 1'b0 || register_v0 !== 32'h0)
        $display("FAIL pause_hold: cycle=%0d pc=%h wr=%b rd=%b v0=%h required pc=bfc0000c wr=0 rd=0 v0=0",
                 i, instr_address, data_write, data_read, register_v0);
      else passed++;
      @(posedge clk);
      #1;
    end
    clk_enable = 1'b1;
    run_to_halt(200, halted);
    total++;
    if (!halted || register_v0 !== 32'h12345678)
      $display("FAIL pause_resume: halted=%b v0=%h required halted=1 v0=12345678", halted, register_v0);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL pause_store: no store seen, required %h@%h", e.data, e.addr);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL pause_store: got %h@%h required %h@%h", o.data, o.addr, e.data, e.addr);
        else passed++;
      end
    end
    total++;
    if (obs_q.size() != 0) $display("FAIL pause_extra_store: extra=%0d required 0", obs_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit halted;
    prog_branch();
    do_reset();
    run_n(2);
    total++;
    if (register_v0 !== 32'd1) $display("FAIL midreset_pre: v0=%h required 1", register_v0);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (instr_address !== 32'hBFC00000 || register_v0 !== 32'h0 || active !== 1'b1)
      $display("FAIL midreset_state: pc=%h v0=%h active=%b required pc=bfc00000 v0=0 active=1",
               instr_address, register_v0, active);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    run_n(1);                       // BEQ commits, branch now pending
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    run_n(1);
    total++;
    if (instr_address !== 32'hBFC00004)
      $display("FAIL midreset_cancel: pc=%h required bfc00004", instr_address);
    else passed++;
    run_to_halt(100, halted);
    total++;
    if (!halted || register_v0 !== 32'd1)
      $display("FAIL midreset_rerun: halted=%b v0=%h required halted=1 v0=1", halted, register_v0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_arith(1'b0);
    test_arith(1'b1);
    test_load_store();
    test_branch();
    test_alu();
    test_clk_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
